hpdcache_mshr_alloc_ctrl: RTL
=============================

Name: hpdcache_mshr_alloc_ctrl

Overview:
Allocation/release controller for the MSHR directory and its set translation table. Tracks per-entry valid bits across MSHR sets × ways and picks a free way in the set indexed by the low bits of the HPDcache set. Drives the translation-table write port on every accepted allocation. Sits between the miss handler (allocation requests) and the refill unit (release requests).

Parameters:
HPDCACHE_SET_WIDTH, 7, width of the HPDcache set index
MSHR_SETS, 4, number of MSHR sets (power of 2, at least 1)
MSHR_WAYS, 4, number of MSHR ways (at least 1)
MSHR_SET_WIDTH, derived, clog2(MSHR_SETS) if MSHR_SETS > 1, else 1
MSHR_WAY_WIDTH, derived, clog2(MSHR_WAYS) if MSHR_WAYS > 1, else 1
CNT_WIDTH, derived, clog2(MSHR_SETS*MSHR_WAYS + 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
alloc_valid_i  in  1  allocation request
alloc_ready_o  out  1  a free way exists in the target MSHR set
alloc_set_i  in  HPDCACHE_SET_WIDTH  HPDcache set of the missing line
alloc_way_o  out  MSHR_WAY_WIDTH  way chosen; valid while alloc_valid_i && alloc_ready_o
tbl_write_o  out  1  translation-table write enable
tbl_dcache_set_o  out  HPDCACHE_SET_WIDTH  translation-table write set (equals alloc_set_i)
tbl_mshr_way_o  out  MSHR_WAY_WIDTH  translation-table write way (equals alloc_way_o)
free_valid_i  in  1  release request, single cycle, always accepted
free_set_i  in  MSHR_SET_WIDTH  MSHR set to release
free_way_i  in  MSHR_WAY_WIDTH  MSHR way to release
pending_cnt_o  out  CNT_WIDTH  number of valid entries
full_o  out  1  all entries valid
empty_o  out  1  no entry valid
err_o  out  1  sticky flag: release of an entry that is not valid
stall_cnt_o  out  32  allocation stall counter (see Optional Feature)

Behaviour:
- State:
  - valid[MSHR_SETS][MSHR_WAYS]
  - rr_ptr[MSHR_SETS] (MSHR_WAY_WIDTH bits each)
  - pending counter
  - err flag
- Reset (rst_i high at a clock edge):
  - clears valid, rr_ptr, counter, err and stall counter.
  - Outputs after reset: alloc_ready_o = 1 if MSHR_WAYS ≥ 1, pending_cnt_o = 0, empty_o = 1, full_o = 0, err_o = 0, tbl_write_o = 0.
  - Reset in the middle of traffic discards all entries. No handshake completes in a cycle where rst_i is high: alloc_ready_o and tbl_write_o are forced to 0.
- Target MSHR set:
  - ms = alloc_set_i[MSHR_SET_WIDTH-1:0] when MSHR_SETS > 1.
  - ms = 0 when MSHR_SETS = 1.
- Way selection (combinational):
  - Take the first way w with valid[ms][w] = 0, searching from rr_ptr[ms] upward modulo MSHR_WAYS.
  - alloc_ready_o = OR over all w of ~valid[ms][w].
- Handshake:
  - Allocation is accepted when alloc_valid_i && alloc_ready_o (0-cycle decision).
  - In that same cycle: tbl_write_o = 1, tbl_dcache_set_o = alloc_set_i, tbl_mshr_way_o = alloc_way_o.
  - At the next edge: valid[ms][w] <= 1 and rr_ptr[ms] <= (w+1) mod MSHR_WAYS.
  - alloc_ready_o does not depend on alloc_valid_i.
- Release:
  - free_valid_i clears valid[free_set_i][free_way_i] at the next edge.
  - If that entry is already 0: no state change and err <= 1. err stays set until reset.
- Simultaneous allocation and release:
  - alloc_ready_o and way selection use the current valid bits. A way being released in this cycle cannot be reused in the same cycle.
  - Both updates apply at the edge.
  - Counter: +1 on allocation only, −1 on a valid release only, unchanged when both occur.
- Boundaries:
  - Set full: alloc_ready_o = 0 even if other sets have free ways.
  - full_o = (cnt == MSHR_SETS*MSHR_WAYS); empty_o = (cnt == 0).
  - Counter never wraps, because allocation is impossible when full.
- All outputs are driven from registered state plus the combinational handshake terms listed above. There are no other combinational paths.

Optional Feature:
Macro: HPDCACHE_MSHR_ALLOC_STATS_EN
- Defined: stall_cnt_o is a 32-bit saturating counter.
  - Increments each cycle that alloc_valid_i && !alloc_ready_o && !rst_i.
  - Holds at 0xFFFFFFFF once reached.
  - Cleared by reset.
- Undefined: no counter logic; stall_cnt_o is tied to 0.

Test Plan:
- Reset, then fill set 0: allocate with alloc_set_i = 0x04, 0x08, 0x0C, 0x10 (all have ms = 0).
  - Ways 0, 1, 2, 3 are granted, one per cycle.
  - tbl_write_o = 1 on each handshake.
  - pending_cnt_o reaches 4.
  - A fifth request 0x14 sees alloc_ready_o = 0.
- Set 0 full, request alloc_set_i = 0x05 (ms = 1):
  - alloc_ready_o = 1, way 0 granted.
  - full_o = 0 until all 16 entries are valid, then full_o = 1.
- Set 0 full, rr_ptr[0] = 0:
  - free way 2 → next allocation to set 0 gets way 2.
  - free ways 1 and 3 → next allocation gets way 3 (round-robin from rr_ptr = 3).
- Release of an already-free entry (set 2, way 1) → err_o = 1 from the next cycle and stays set; pending_cnt_o unchanged.
- Same-cycle allocation and release on full set 1:
  - release of way 0 with alloc_valid_i = 1 → alloc_ready_o = 0 that cycle.
  - Next cycle the allocation is granted way 0.
  - pending_cnt_o goes 16 → 15 → 16.
- With HPDCACHE_MSHR_ALLOC_STATS_EN defined: 10 cycles of a blocked request → stall_cnt_o = 10. Assert rst_i mid-traffic → next cycle all counters = 0, empty_o = 1, err_o = 0.

Source files
------------

// File: rtl/hpdcache_mshr_alloc_ctrl.sv
// ----------------------------------------------------------------------------
// hpdcache_mshr_alloc_ctrl
//
// Allocation/release controller for the MSHR directory and its set
// translation table. Keeps one valid bit per MSHR entry (sets x ways). For an
// allocation it picks a free way in the MSHR set addressed by the low bits of
// the HPDcache set, searching round-robin from a per-set pointer. It also
// drives the translation-table write port on every accepted allocation.
//
// Handshake: an allocation completes in any cycle where alloc_valid_i and
// alloc_ready_o are both high. alloc_ready_o never depends on alloc_valid_i.
// Releases (free_valid_i) are single-cycle and always accepted.
//
// Optional build macro: HPDCACHE_MSHR_ALLOC_STATS_EN enables a 32-bit
// saturating allocation-stall counter on stall_cnt_o. Otherwise it is tied to 0.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   alloc_valid_i/ready_o  allocation handshake
//   alloc_set_i            HPDcache set of the missing line
//   alloc_way_o            chosen MSHR way (meaningful while ready_o is high)
//   tbl_write_o            translation-table write enable
//   tbl_dcache_set_o       translation-table write set
//   tbl_mshr_way_o         translation-table write way
//   free_valid_i/set_i/way_i  release of one MSHR entry
//   pending_cnt_o          number of valid entries
//   full_o, empty_o        all valid / none valid
//   err_o                  sticky: an entry that was not valid was released
//   stall_cnt_o            allocation stall counter
// ----------------------------------------------------------------------------
module hpdcache_mshr_alloc_ctrl #(
   parameter int unsigned HPDCACHE_SET_WIDTH = 7,
   parameter int unsigned MSHR_SETS          = 4,
   parameter int unsigned MSHR_WAYS          = 4,
   localparam int unsigned MSHR_SET_WIDTH    = (MSHR_SETS > 1) ? $clog2(MSHR_SETS) : 1,
   localparam int unsigned MSHR_WAY_WIDTH    = (MSHR_WAYS > 1) ? $clog2(MSHR_WAYS) : 1,
   localparam int unsigned CNT_WIDTH         = $clog2(MSHR_SETS*MSHR_WAYS + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          alloc_valid_i,
   output logic                          alloc_ready_o,
   input  logic [HPDCACHE_SET_WIDTH-1:0] alloc_set_i,
   output logic [MSHR_WAY_WIDTH-1:0]     alloc_way_o,
   output logic                          tbl_write_o,
   output logic [HPDCACHE_SET_WIDTH-1:0] tbl_dcache_set_o,
   output logic [MSHR_WAY_WIDTH-1:0]     tbl_mshr_way_o,
   input  logic                          free_valid_i,
   input  logic [MSHR_SET_WIDTH-1:0]     free_set_i,
   input  logic [MSHR_WAY_WIDTH-1:0]     free_way_i,
   output logic [CNT_WIDTH-1:0]          pending_cnt_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic                          err_o,
   output logic [31:0]                   stall_cnt_o
);

   localparam int unsigned N_ENTRIES = MSHR_SETS * MSHR_WAYS;

   logic [MSHR_SETS-1:0][MSHR_WAYS-1:0]      valid_q;
   logic [MSHR_SETS-1:0][MSHR_WAY_WIDTH-1:0] rr_ptr_q;
   logic [CNT_WIDTH-1:0]                     cnt_q;
   logic                                     err_q;

   logic [MSHR_SET_WIDTH-1:0] ms;
   logic [MSHR_WAYS-1:0]      set_valid;
   logic [MSHR_WAY_WIDTH-1:0] sel_way;
   logic [MSHR_WAY_WIDTH-1:0] next_rr;
   logic                      set_has_free;
   logic                      alloc_fire;
   logic                      free_in_range;
   logic                      free_hit;

   // Target MSHR set: low bits of the HPDcache set (always 0 with one set).
   if (MSHR_SETS > 1) begin : g_ms_multi
      assign ms = alloc_set_i[MSHR_SET_WIDTH-1:0];
   end else begin : g_ms_single
      assign ms = '0;
   end

   assign set_valid    = valid_q[ms];
   assign set_has_free = ~&set_valid;

   // First free way at or after the round-robin pointer, wrapping modulo
   // MSHR_WAYS. Uses the current valid bits only, so a way released in this
   // cycle is not visible to the search until the next cycle.
   always_comb begin : way_select
      logic [MSHR_WAY_WIDTH-1:0] cand;
      logic                      found;
      cand    = '0;
      found   = 1'b0;
      sel_way = '0;
      for (int i = 0; i < int'(MSHR_WAYS); i++) begin
         cand = MSHR_WAY_WIDTH'((int'(rr_ptr_q[ms]) + i) % int'(MSHR_WAYS));
         if (!found && !set_valid[cand]) begin
            found   = 1'b1;
            sel_way = cand;
         end
      end
   end

   assign next_rr = (sel_way == MSHR_WAY_WIDTH'(MSHR_WAYS - 1)) ? '0
                                                                 : sel_way + MSHR_WAY_WIDTH'(1);

   // No handshake may complete while reset is asserted.
   assign alloc_ready_o = set_has_free & ~rst_i;
   assign alloc_fire    = alloc_valid_i & alloc_ready_o;

   // Out-of-range release coordinates never match a valid entry, so they are
   // reported through err like any other release of a non-valid entry.
   assign free_in_range = (int'(free_set_i) < int'(MSHR_SETS)) &&
                          (int'(free_way_i) < int'(MSHR_WAYS));
   assign free_hit      = free_valid_i & free_in_range & valid_q[free_set_i][free_way_i];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         // The allocated way is always a non-valid entry and a release only
         // clears a valid one, so these two updates never target the same bit.
         if (free_hit) begin
            valid_q[free_set_i][free_way_i] <= 1'b0;
         end
         if (alloc_fire) begin
            valid_q[ms][sel_way] <= 1'b1;
            rr_ptr_q[ms]         <= next_rr;
         end
         if (free_valid_i && !free_hit) begin
            err_q <= 1'b1;
         end
         if (alloc_fire && !free_hit) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end else if (!alloc_fire && free_hit) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
         end
      end
   end

`ifdef HPDCACHE_MSHR_ALLOC_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (alloc_valid_i && !alloc_ready_o && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

   assign alloc_way_o      = sel_way;
   assign tbl_write_o      = alloc_fire;
   assign tbl_dcache_set_o = alloc_set_i;
   assign tbl_mshr_way_o   = sel_way;
   assign pending_cnt_o    = cnt_q;
   assign full_o           = (cnt_q == CNT_WIDTH'(N_ENTRIES));
   assign empty_o          = (cnt_q == '0);
   assign err_o            = err_q;

endmodule
